// File: rtl/iob_bus_arbiter.sv
// rtl/iob_bus_arbiter.sv - two-master round-robin IOb arbiter with slave-timeout watchdog
module iob_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                timeout_err,
  input  logic                err_clr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, next_state;
  logic             grant, last_grant, win, load, expire, done;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    m_valid    = 1'b0;
    expire     = 1'b0;
    done       = 1'b0;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    i_rdata    = m_rdata;
    d_rdata    = m_rdata;
    // On a tie the master not served last wins; otherwise the sole requester.
    if (i_valid && d_valid) win = ~last_grant;
    else                    win = d_valid ? GRANT_D : GRANT_I;
    case (state)
      IDLE: begin
        if (i_valid || d_valid) begin
          load       = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        m_valid = 1'b1;
        expire  = (TIMEOUT != 0) && !m_ready && (cnt == CNT_LAST);
        done    = m_ready || expire;
        if (done) begin
          next_state = IDLE;
          if (grant == GRANT_D) d_ready = 1'b1;
          else                  i_ready = 1'b1;
        end
        if (expire) begin
          if (grant == GRANT_D) d_rdata = '0;
          else                  i_rdata = '0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_addr      <= '0;
      m_wdata     <= '0;
      m_wstrb     <= '0;
      grant       <= GRANT_I;
      last_grant  <= GRANT_D;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (load) begin
        m_addr  <= (win == GRANT_D) ? d_addr  : i_addr;
        m_wdata <= (win == GRANT_D) ? d_wdata : i_wdata;
        m_wstrb <= (win == GRANT_D) ? d_wstrb : i_wstrb;
        grant   <= win;
        cnt     <= '0;
      end else if (state == BUSY && !m_ready && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      if (done) last_grant <= grant;
      // A new expiry outranks a same-cycle clear so the event is never lost.
      if (expire)       timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// tb/tb_iob_bus_arbiter.sv - directed self-checking bench for iob_bus_arbiter
module tb_iob_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, d_valid, m_ready, err_clr;
  logic [31:0] i_addr, d_addr, i_wdata, d_wdata, m_rdata;
  logic [3:0]  i_wstrb, d_wstrb;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        i_ready, d_ready, m_valid, timeout_err;

  int checks = 0;
  int errors = 0;
  int i_done = 0;
  int d_done = 0;

  iob_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    i_valid = 0; d_valid = 0; m_ready = 0; err_clr = 0;
    i_addr = 0; d_addr = 0; i_wdata = 0; d_wdata = 0; m_rdata = 0;
    i_wstrb = 0; d_wstrb = 0;
    tick(); settle();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wstrb", m_wstrb, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_timeout_err", timeout_err, 0);
    tick();
    rst = 1'b1;

    // Tie fairness, zero-wait slave: expect I,D,I,D
    i_valid = 1; d_valid = 1; i_addr = 32'h10; d_addr = 32'h20; m_ready = 1;
    for (int n = 0; n < 4; n++) begin
      tick(); settle();
      chk("tie_m_valid", m_valid, 1);
      chk("tie_m_addr", m_addr, (n % 2) ? 32'h20 : 32'h10);
      chk("tie_i_ready", i_ready, (n % 2) ? 0 : 1);
      chk("tie_d_ready", d_ready, (n % 2) ? 1 : 0);
      if (i_ready) i_done++;
      if (d_ready) d_done++;
      tick(); settle();
      chk("tie_idle_m_valid", m_valid, 0);
      chk("tie_idle_ready", {i_ready, d_ready}, 0);
    end
    chk("tie_i_count", i_done, 2);
    chk("tie_d_count", d_done, 2);
    i_valid = 0; d_valid = 0; m_ready = 0;

    // Single read with one slave wait state
    i_valid = 1; i_addr = 32'h100; i_wstrb = 0;
    tick(); settle();
    chk("rd_m_valid", m_valid, 1);
    chk("rd_m_addr", m_addr, 32'h100);
    chk("rd_m_wstrb", m_wstrb, 0);
    chk("rd_wait_i_ready", i_ready, 0);
    tick();
    m_ready = 1; m_rdata = 32'hCAFEF00D;
    settle();
    chk("rd_i_ready", i_ready, 1);
    chk("rd_i_rdata", i_rdata, 32'hCAFEF00D);
    chk("rd_d_ready", d_ready, 0);
    tick();
    i_valid = 0; m_ready = 0;
    settle();
    chk("rd_after_m_valid", m_valid, 0);
    chk("rd_after_i_ready", i_ready, 0);

    // Data write held across a 3-cycle slave wait
    d_valid = 1; d_addr = 32'h8000_0004; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      chk("wr_m_addr", m_addr, 32'h8000_0004);
      chk("wr_m_wdata", m_wdata, 32'h12345678);
      chk("wr_m_wstrb", m_wstrb, 4'b0011);
      chk("wr_wait_d_ready", d_ready, 0);
    end
    tick();
    m_ready = 1;
    settle();
    chk("wr_d_ready", d_ready, 1);
    chk("wr_hold_m_addr", m_addr, 32'h8000_0004);
    chk("wr_i_ready", i_ready, 0);
    tick();
    d_valid = 0; m_ready = 0;
    settle();
    chk("wr_after_d_ready", d_ready, 0);
    chk("wr_after_m_valid", m_valid, 0);

    // Timeout with silent slave, then err_clr
    d_valid = 1; d_addr = 32'h44; m_rdata = 32'hDEADBEEF;
    for (int k = 1; k < 8; k++) begin
      tick(); settle();
      chk("to_wait_d_ready", d_ready, 0);
    end
    tick(); settle();
    chk("to_d_ready", d_ready, 1);
    chk("to_d_rdata", d_rdata, 0);
    chk("to_err_before", timeout_err, 0);
    d_valid = 0;
    tick(); settle();
    chk("to_err_set", timeout_err, 1);
    chk("to_m_valid", m_valid, 0);
    err_clr = 1;
    tick();
    err_clr = 0;
    settle();
    chk("to_err_cleared", timeout_err, 0);

    // Expiry coincident with err_clr keeps the flag set
    d_valid = 1;
    for (int k = 1; k < 8; k++) tick();
    tick(); settle();
    chk("to2_d_ready", d_ready, 1);
    err_clr = 1; d_valid = 0;
    tick();
    err_clr = 0;
    settle();
    chk("to2_err_kept", timeout_err, 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    settle();
    chk("to2_err_cleared", timeout_err, 0);

    // m_ready on the expiry cycle wins; stray m_ready in IDLE ignored
    i_valid = 1; i_addr = 32'h200;
    for (int k = 1; k < 8; k++) tick();
    tick();
    m_ready = 1; m_rdata = 32'h55AA;
    settle();
    chk("bnd_i_ready", i_ready, 1);
    chk("bnd_i_rdata", i_rdata, 32'h55AA);
    tick();
    i_valid = 0;
    settle();
    chk("bnd_err", timeout_err, 0);
    chk("bnd_stray_ready", {i_ready, d_ready}, 0);
    chk("bnd_stray_m_valid", m_valid, 0);
    tick(); settle();
    chk("bnd_stray_ready2", {i_ready, d_ready}, 0);
    m_ready = 0;

    // Reset while BUSY
    d_valid = 1; d_addr = 32'hD00; d_wdata = 32'hABCD; d_wstrb = 4'hF;
    tick(); settle();
    chk("mr_m_valid", m_valid, 1);
    chk("mr_m_addr", m_addr, 32'hD00);
    tick(); settle();
    rst = 0; m_ready = 1;
    settle();
    chk("mr_rst_m_valid", m_valid, 0);
    chk("mr_rst_m_addr", m_addr, 0);
    chk("mr_rst_m_wdata", m_wdata, 0);
    chk("mr_rst_m_wstrb", m_wstrb, 0);
    chk("mr_rst_ready", {i_ready, d_ready}, 0);
    tick();
    rst = 1; i_valid = 1; i_addr = 32'h1A0;
    tick(); settle();
    chk("mr_first_m_addr", m_addr, 32'h1A0);
    chk("mr_first_i_ready", i_ready, 1);
    chk("mr_first_d_ready", d_ready, 0);
    tick();
    i_valid = 0;
    tick(); settle();
    chk("mr_second_m_addr", m_addr, 32'hD00);
    chk("mr_second_d_ready", d_ready, 1);
    tick();
    d_valid = 0; m_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
